// File: rtl/dma_responder.sv
// Completer-side DMA stand-in: serves line reads and absorbs line writes against
// an internal cache-line memory, with a backdoor port for preload and inspection.
module dma_responder #(
  parameter int              ADDR_WIDTH = 64,
  parameter int              SIZE_WIDTH = 43,
  parameter int              DATA_WIDTH = 512,
  parameter int              MEM_DEPTH  = 1024,
  parameter longint unsigned BASE_ADDR  = 0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  input  logic [SIZE_WIDTH-1:0]        rd_size,
  input  logic                         rd_go,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         empty,
  output logic                         rd_done,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [SIZE_WIDTH-1:0]        wr_size,
  input  logic                         wr_go,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         full,
  output logic                         wr_done,
  input  logic                         bd_we,
  input  logic                         bd_re,
  input  logic [$clog2(MEM_DEPTH)-1:0] bd_line,
  input  logic [DATA_WIDTH-1:0]        bd_wdata,
  output logic [DATA_WIDTH-1:0]        bd_rdata,
  output logic                         err
);

  localparam int LW = $clog2(MEM_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [SIZE_WIDTH-1:0] SIZE_ONE  = SIZE_WIDTH'(1);
  localparam logic [CW-1:0]         FIFO_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_DRAIN} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_ACCEPT, WR_FLUSH} wr_state_t;

  function automatic logic [LW-1:0] addr_to_line(input logic [ADDR_WIDTH-1:0] addr);
    return LW'((addr - ADDR_WIDTH'(BASE_ADDR)) >> 6);
  endfunction

  logic [DATA_WIDTH-1:0] mem     [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rd_fifo [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] wr_fifo [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_q;

  rd_state_t             rd_state_reg;
  logic [LW-1:0]         rd_base_reg;
  logic [SIZE_WIDTH-1:0] rd_size_reg, rd_issued_reg, rd_popped_reg;
  logic [PW-1:0]         rd_wptr_reg, rd_rptr_reg;
  logic [CW-1:0]         rd_count_reg;
  logic                  rd_done_reg;

  wr_state_t             wr_state_reg;
  logic [LW-1:0]         wr_base_reg;
  logic [SIZE_WIDTH-1:0] wr_size_reg, wr_accepted_reg, wr_committed_reg;
  logic [PW-1:0]         wr_wptr_reg, wr_rptr_reg;
  logic [CW-1:0]         wr_count_reg;
  logic                  wr_done_reg;

  logic                  bd_pending_reg;
  logic [DATA_WIDTH-1:0] bd_hold_reg;
  logic                  err_reg;

  logic                  rd_fetch, rd_pop, wr_full, wr_push, wr_drain, mem_we;
  logic [LW-1:0]         mem_raddr, mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Backdoor always wins a memory port; the channel using that port idles for the cycle.
  always_comb begin
    rd_fetch  = (rd_state_reg == RD_FETCH) && !rd_go && !bd_re &&
                (rd_issued_reg != rd_size_reg) && (rd_count_reg != FIFO_FULL);
    rd_pop    = rd_en && (rd_count_reg != '0) && !rd_go;
    wr_full   = (wr_state_reg == WR_IDLE) || (wr_count_reg == FIFO_FULL) ||
                (wr_accepted_reg == wr_size_reg);
    wr_push   = wr_en && !wr_full && !wr_go;
    wr_drain  = (wr_state_reg != WR_IDLE) && (wr_count_reg != '0) && !bd_we && !wr_go;
    mem_raddr = bd_re ? bd_line : rd_base_reg + LW'(rd_issued_reg);
    mem_we    = bd_we || wr_drain;
    mem_waddr = bd_we ? bd_line : wr_base_reg + LW'(wr_committed_reg);
    mem_wdata = bd_we ? bd_wdata : wr_fifo[wr_rptr_reg];
  end

  // Fetched lines land directly in the read FIFO slot, giving one cycle of memory latency.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
    mem_q <= mem[mem_raddr];
    if (rd_fetch)
      rd_fifo[rd_wptr_reg] <= mem[mem_raddr];
  end

  always_ff @(posedge clk) begin
    if (wr_push)
      wr_fifo[wr_wptr_reg] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_reg  <= RD_IDLE;
      rd_base_reg   <= '0;
      rd_size_reg   <= '0;
      rd_issued_reg <= '0;
      rd_popped_reg <= '0;
      rd_wptr_reg   <= '0;
      rd_rptr_reg   <= '0;
      rd_count_reg  <= '0;
      rd_done_reg   <= 1'b0;
    end else if (rd_go) begin
      rd_base_reg   <= addr_to_line(rd_addr);
      rd_size_reg   <= rd_size;
      rd_issued_reg <= '0;
      rd_popped_reg <= '0;
      rd_wptr_reg   <= '0;
      rd_rptr_reg   <= '0;
      rd_count_reg  <= '0;
      rd_done_reg   <= (rd_size == '0);
      rd_state_reg  <= (rd_size == '0) ? RD_IDLE : RD_FETCH;
    end else begin
      if (rd_fetch) begin
        rd_issued_reg <= rd_issued_reg + SIZE_ONE;
        rd_wptr_reg   <= rd_wptr_reg + 1'b1;
      end
      if (rd_pop) begin
        rd_popped_reg <= rd_popped_reg + SIZE_ONE;
        rd_rptr_reg   <= rd_rptr_reg + 1'b1;
      end
      rd_count_reg <= rd_count_reg + CW'(rd_fetch) - CW'(rd_pop);
      if (rd_state_reg == RD_FETCH && rd_issued_reg == rd_size_reg)
        rd_state_reg <= RD_DRAIN;
      if (rd_pop && rd_popped_reg + SIZE_ONE == rd_size_reg) begin
        rd_done_reg  <= 1'b1;
        rd_state_reg <= RD_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_reg     <= WR_IDLE;
      wr_base_reg      <= '0;
      wr_size_reg      <= '0;
      wr_accepted_reg  <= '0;
      wr_committed_reg <= '0;
      wr_wptr_reg      <= '0;
      wr_rptr_reg      <= '0;
      wr_count_reg     <= '0;
      wr_done_reg      <= 1'b0;
    end else if (wr_go) begin
      wr_base_reg      <= addr_to_line(wr_addr);
      wr_size_reg      <= wr_size;
      wr_accepted_reg  <= '0;
      wr_committed_reg <= '0;
      wr_wptr_reg      <= '0;
      wr_rptr_reg      <= '0;
      wr_count_reg     <= '0;
      wr_done_reg      <= (wr_size == '0);
      wr_state_reg     <= (wr_size == '0) ? WR_IDLE : WR_ACCEPT;
    end else begin
      if (wr_push) begin
        wr_accepted_reg <= wr_accepted_reg + SIZE_ONE;
        wr_wptr_reg     <= wr_wptr_reg + 1'b1;
      end
      if (wr_drain) begin
        wr_committed_reg <= wr_committed_reg + SIZE_ONE;
        wr_rptr_reg      <= wr_rptr_reg + 1'b1;
      end
      wr_count_reg <= wr_count_reg + CW'(wr_push) - CW'(wr_drain);
      if (wr_state_reg == WR_ACCEPT && wr_accepted_reg == wr_size_reg)
        wr_state_reg <= WR_FLUSH;
      if (wr_drain && wr_committed_reg + SIZE_ONE == wr_size_reg) begin
        wr_done_reg  <= 1'b1;
        wr_state_reg <= WR_IDLE;
      end
    end
  end

  // bd_rdata follows the shared read register for one cycle, then holds that value.
  always_ff @(posedge clk) begin
    if (rst) begin
      bd_pending_reg <= 1'b0;
      bd_hold_reg    <= '0;
      err_reg        <= 1'b0;
    end else begin
      bd_pending_reg <= bd_re;
      if (bd_pending_reg)
        bd_hold_reg <= mem_q;
      if ((rd_en && rd_count_reg == '0) || (wr_en && wr_full))
        err_reg <= 1'b1;
    end
  end

  assign rd_data  = rd_fifo[rd_rptr_reg];
  assign empty    = (rd_count_reg == '0);
  assign rd_done  = rd_done_reg;
  assign full     = wr_full;
  assign wr_done  = wr_done_reg;
  assign bd_rdata = bd_pending_reg ? mem_q : bd_hold_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_dma_responder.sv
// Randomized bench for dma_responder: a line-array model of memory predicts every
// read beat, backdoor readback and done/full/empty/err flag.
module tb_dma_responder;

  localparam int AW = 64;
  localparam int SW = 43;
  localparam int DW = 512;
  localparam int MD = 1024;
  localparam int FD = 4;
  localparam int LW = $clog2(MD);

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [SW-1:0] rd_size, wr_size;
  logic          rd_go, rd_en, wr_go, wr_en;
  logic [DW-1:0] rd_data, wr_data, bd_wdata, bd_rdata;
  logic          empty, rd_done, full, wr_done, err;
  logic          bd_we, bd_re;
  logic [LW-1:0] bd_line;

  logic [DW-1:0] model [MD];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dma_responder #(
    .ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .DATA_WIDTH(DW),
    .MEM_DEPTH(MD), .BASE_ADDR(0), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_size(rd_size), .rd_go(rd_go), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .rd_done(rd_done),
    .wr_addr(wr_addr), .wr_size(wr_size), .wr_go(wr_go), .wr_en(wr_en),
    .wr_data(wr_data), .full(full), .wr_done(wr_done),
    .bd_we(bd_we), .bd_re(bd_re), .bd_line(bd_line), .bd_wdata(bd_wdata),
    .bd_rdata(bd_rdata), .err(err)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lidx(input logic [AW-1:0] addr, input int n);
    return int'(((addr >> 6) + 64'(n)) % 64'(MD));
  endfunction

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic bd_write(input int line, input logic [DW-1:0] val);
    bd_we = 1'b1; bd_line = LW'(line); bd_wdata = val;
    model[line] = val;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic bd_check(input string tag, input int line);
    bd_re = 1'b1; bd_line = LW'(line);
    tick();
    bd_re = 1'b0;
    check(tag, bd_rdata, model[line]);
  endtask

  // Reads `size` lines; stops early after `stop` pops when stop >= 0.
  task automatic do_read(input logic [AW-1:0] addr, input int size, input int en_pct,
                         input int bd_pct, input int stop);
    int popped = 0;
    int cyc = 0;
    bit bd_pend = 1'b0;
    int bd_pl = 0;
    bit go;
    rd_addr = addr; rd_size = SW'(size); rd_go = 1'b1;
    tick();
    rd_go = 1'b0;
    if (size == 0) begin
      check("rd0_done", rd_done, 1);
      check("rd0_empty", empty, 1);
      $display("read  addr=%0h size=0", addr);
      return;
    end
    check("rd_empty_t1", empty, 1);
    tick();
    check("rd_empty_t2", empty, 0);
    while (popped < size && cyc < 500 && popped != stop) begin
      if (bd_pend) check("rd_bd_rdata", bd_rdata, model[bd_pl]);
      bd_pend = ($urandom_range(99) < bd_pct);
      bd_pl   = $urandom_range(MD - 1);
      bd_re   = bd_pend;
      bd_line = LW'(bd_pl);
      go = !empty && ($urandom_range(99) < en_pct);
      rd_en = go;
      if (go) begin
        check("rd_data", rd_data, model[lidx(addr, popped)]);
        if (popped == size - 1) check("rd_done_early", rd_done, 0);
        popped++;
      end
      tick();
      cyc++;
    end
    rd_en = 1'b0; bd_re = 1'b0;
    if (bd_pend) check("rd_bd_rdata", bd_rdata, model[bd_pl]);
    $display("read  addr=%0h size=%0d popped=%0d cycles=%0d", addr, size, popped, cyc);
    if (stop >= 0) return;
    check("rd_popped", popped, size);
    check("rd_done", rd_done, 1);
    check("rd_empty_end", empty, 1);
  endtask

  // Writes `size` lines of base_val+n; the backdoor occupies the write port for the
  // first `hold` cycles, writing hold_val to hold_line.
  task automatic do_write(input logic [AW-1:0] addr, input int size, input int en_pct,
                          input int hold, input int hold_line, input logic [DW-1:0] base_val);
    int pushed = 0;
    int cyc = 0;
    int k = 0;
    bit go;
    logic [DW-1:0] hold_val;
    hold_val = rand_line();
    wr_addr = addr; wr_size = SW'(size); wr_go = 1'b1;
    tick();
    wr_go = 1'b0;
    if (size == 0) begin
      check("wr0_done", wr_done, 1);
      check("wr0_full", full, 1);
      $display("write addr=%0h size=0", addr);
      return;
    end
    while (pushed < size && cyc < 500) begin
      if (cyc == 0) check("wr_full_start", full, 0);
      if (hold > FD && cyc == FD) check("wr_full_stall", full, 1);
      bd_we = (cyc < hold);
      bd_line = LW'(hold_line);
      bd_wdata = hold_val;
      if (cyc < hold) model[hold_line] = hold_val;
      go = !full && ($urandom_range(99) < en_pct);
      wr_en = go;
      wr_data = base_val + DW'(pushed);
      if (go) begin
        model[lidx(addr, pushed)] = wr_data;
        pushed++;
      end
      tick();
      cyc++;
    end
    wr_en = 1'b0; bd_we = 1'b0;
    check("wr_pushed", pushed, size);
    check("wr_full_after", full, 1);
    if (hold == 0) begin
      check("wr_done_early", wr_done, 0);
      tick();
    end else begin
      while (!wr_done && k < 50) begin
        tick();
        k++;
      end
    end
    check("wr_done", wr_done, 1);
    $display("write addr=%0h size=%0d cycles=%0d", addr, size, cyc);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    rd_addr = '0; rd_size = '0; rd_go = 1'b0; rd_en = 1'b0;
    wr_addr = '0; wr_size = '0; wr_go = 1'b0; wr_en = 1'b0; wr_data = '0;
    bd_we = 1'b0; bd_re = 1'b0; bd_line = '0; bd_wdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_empty", empty, 1);
    check("rst_full", full, 1);
    check("rst_rd_done", rd_done, 0);
    check("rst_wr_done", wr_done, 0);
    check("rst_err", err, 0);
    check("rst_bd_rdata", bd_rdata, 0);

    for (int i = 0; i < MD; i++) bd_write(i, (i < 8) ? DW'(i) : rand_line());
    bd_check("bd_line3", 3);

    // Lines 1..4 hold 1..4.
    do_read(64'h40, 4, 100, 0, -1);

    do_write(64'h100, 6, 100, 0, 0, DW'(32'hA0));
    for (int i = 4; i < 10; i++) bd_check("wr_readback", i);

    // Backdoor holds the write port so the FIFO fills up.
    do_write(64'd20 * 64, 6, 100, 7, 900, rand_line());
    for (int i = 20; i < 26; i++) bd_check("wr_stall_readback", i);
    bd_check("bd_hold_line", 900);

    do_read(64'd1022 * 64, 4, 100, 0, -1);

    rd_addr = 64'h80; rd_size = '0; wr_addr = 64'h80; wr_size = '0;
    rd_go = 1'b1; wr_go = 1'b1;
    tick();
    rd_go = 1'b0; wr_go = 1'b0;
    check("size0_rd_done", rd_done, 1);
    check("size0_wr_done", wr_done, 1);
    check("size0_empty", empty, 1);
    check("size0_full", full, 1);
    check("size0_err", err, 0);
    $display("read+write size=0 together");

    do_read(64'd300 * 64, 5, 100, 0, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_empty", empty, 1);
    check("midrst_rd_done", rd_done, 0);
    check("midrst_full", full, 1);
    check("midrst_err", err, 0);
    for (int i = 0; i < 3; i++) bd_write(310 + i, rand_line());
    do_read(64'd310 * 64, 3, 100, 0, -1);

    for (int t = 0; t < 16; t++) begin
      logic [AW-1:0] a;
      a = {$urandom, $urandom};
      if ($urandom_range(1) == 0)
        do_read(a, $urandom_range(10, 1), $urandom_range(100, 30), 20, -1);
      else
        do_write(a, $urandom_range(10, 1), $urandom_range(100, 30), 0, 0, rand_line());
    end

    do_read(64'h0, 2, 100, 0, -1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("err_rd_empty", err, 1);
    check("err_rd_done_kept", rd_done, 1);
    check("err_empty_kept", empty, 1);
    wr_addr = 64'h0; wr_en = 1'b1; wr_data = rand_line();
    tick();
    wr_en = 1'b0;
    check("err_wr_full", err, 1);
    check("err_full_kept", full, 1);
    tick();
    check("err_sticky", err, 1);
    bd_check("err_mem_kept", 0);
    $display("err probe: rd_en on empty, wr_en on full");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dma_responder.md
Name: dma_responder

Overview:
- Completer side of the AFU DMA interface: serves rd_go/rd_en requests from an internal cache-line memory and absorbs wr_go/wr_en traffic into the same memory.
- Standalone stand-in for the HAL DMA engine, so miner/AFU logic can be simulated and run on-chip without CCI-P.
- A backdoor port lets a bench or loader preload and inspect memory.

Parameters:
- ADDR_WIDTH, 64, virtual byte address width.
- SIZE_WIDTH, 43, transfer size width in cache lines.
- DATA_WIDTH, 512, cache-line width.
- MEM_DEPTH, 1024, memory depth in lines (power of 2).
- BASE_ADDR, 0, byte address that maps to line 0.
- FIFO_DEPTH, 4, depth of the read and write FIFOs (power of 2, at least 2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rd_addr  in  ADDR_WIDTH  start byte address of a read
- rd_size  in  SIZE_WIDTH  read length in lines
- rd_go  in  1  start read, 1-cycle pulse
- rd_en  in  1  pop rd_data
- rd_data  out  DATA_WIDTH  head of read FIFO
- empty  out  1  read FIFO empty
- rd_done  out  1  all rd_size lines popped
- wr_addr  in  ADDR_WIDTH  start byte address of a write
- wr_size  in  SIZE_WIDTH  write length in lines
- wr_go  in  1  start write, 1-cycle pulse
- wr_en  in  1  push wr_data
- wr_data  in  DATA_WIDTH  write line
- full  out  1  cannot accept wr_en
- wr_done  out  1  all wr_size lines committed to memory
- bd_we  in  1  backdoor write
- bd_re  in  1  backdoor read
- bd_line  in  $clog2(MEM_DEPTH)  backdoor line index
- bd_wdata  in  DATA_WIDTH  backdoor write data
- bd_rdata  out  DATA_WIDTH  backdoor read data, 1 cycle after bd_re
- err  out  1  sticky protocol error

Behaviour:
- Line index = ((addr - BASE_ADDR) >> 6 + n) mod MEM_DEPTH, where n is the line number within the transfer. addr[5:0] is ignored. The index wraps silently past MEM_DEPTH-1.
- Reset: all FSMs return to IDLE and both FIFOs and all counters clear. empty=1, full=1, rd_done=0, wr_done=0, err=0, bd_rdata=0. Memory contents are undefined.
- Reset asserted mid-transfer aborts the transfer with the same result.
- Read FSM, states IDLE / FETCH / DRAIN:
  - rd_go in any state latches addr and size, flushes the read FIFO, clears counters and rd_done, then enters FETCH.
  - FETCH issues one memory read per cycle while (fifo occupancy + in-flight) < FIFO_DEPTH and issued < size. Memory latency is 1 cycle; data is pushed into the FIFO on return.
  - First line is visible (empty=0) no earlier than 2 cycles after rd_go, and no later than 2 cycles if there is no backdoor conflict.
  - When issued == size, go to DRAIN.
  - rd_en with empty=0 pops the head.
  - When popped == size: rd_done=1 next cycle, state IDLE. rd_done stays high until the next rd_go or reset.
  - rd_size=0: rd_done=1 on the cycle after rd_go, empty stays 1.
  - rd_en while empty=1: ignored, err set.
- Write FSM, states IDLE / ACCEPT / FLUSH:
  - wr_go in any state latches addr and size, clears the write FIFO, counters and wr_done, then enters ACCEPT.
  - full = (state==IDLE) | fifo full | accepted == size.
  - wr_en with full=0 pushes wr_data. The head is written to memory in the same cycle it is at the FIFO head, one line per cycle.
  - When accepted == size, go to FLUSH. When committed == size, wr_done=1 next cycle, state IDLE. wr_done is sticky until the next wr_go or reset.
  - wr_size=0: wr_done=1 on the cycle after wr_go.
  - wr_en while full=1: ignored, err set.
- Backdoor:
  - bd_we has priority on the memory write port. A write drain stalls for that cycle.
  - bd_re has priority on the read port. A fetch stalls for that cycle.
  - Simultaneous bd_we and bd_re to the same line return the old data.
- Read and write channels are independent and may run concurrently. Overlapping address ranges give read-before-write per line, with no ordering guarantee across channels.
- err clears only on rst.

Test Plan:
- Preload lines 0..7 with value i via backdoor. rd_addr=0x40, rd_size=4, rd_go, rd_en whenever ~empty → data 1,2,3,4 in order. First empty=0 at rd_go+2. rd_done=1 one cycle after the 4th pop.
- wr_addr=0x100, wr_size=6, wr_go, push 0xA0..0xA5, holding wr_en continuously → full asserts after FIFO_DEPTH pushes if the drain lags. wr_done=1. Backdoor reads of lines 4..9 return 0xA0..0xA5.
- MEM_DEPTH=1024, rd_addr=BASE+1022*64, rd_size=4 → lines 1022, 1023, 0, 1 are returned.
- rd_size=0 and wr_size=0 → rd_done and wr_done=1 one cycle after go, empty=1, full=1, err=0.
- rd_en while empty and wr_en while full → err=1 and stays 1. Memory and pop count are unchanged.
- rst mid-read after 2 of 5 pops → next cycle empty=1, rd_done=0, full=1. A new rd_go with rd_size=3 completes normally.
